// File: rtl/ram_dp_be_if.sv
// One access port of ram_dp_be: request (en/addr/we/d) and read return (q/rvalid).
interface ram_dp_be_if #(
  parameter int AW = 11,
  parameter int MW = 8,
  parameter int DW = 8
);
  logic             en;
  logic [AW-1:0]    addr;
  logic [MW-1:0]    we;
  logic [MW*DW-1:0] d;
  logic [MW*DW-1:0] q;
  logic             rvalid;

  // Handshake: en is a single-cycle request that is always accepted (no ready,
  // no back-pressure); rvalid is high for exactly one cycle per accepted request,
  // RD_LAT cycles after it, and q is only meaningful while rvalid is high.
  modport master (output en, addr, we, d, input q, rvalid);
  modport slave  (input en, addr, we, d, output q, rvalid);
endinterface

// File: rtl/ram_dp_be.sv
// True dual-port byte-enable RAM, RD_LAT 1/2, per-port read-during-write mode,
// cross-port collision pulse; optional saturating counter under RAM_COLL_STATS_EN.
module ram_dp_be #(
  parameter int AW       = 11,
  parameter int MW       = 8,
  parameter int DW       = 8,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic       clk,
  input  logic       resetn,
  ram_dp_be_if.slave p0,
  ram_dp_be_if.slave p1,
  output logic       coll
`ifdef RAM_COLL_STATS_EN
  ,
  output logic [15:0] coll_cnt
`endif
);
  localparam int W     = MW * DW;
  localparam int DEPTH = 1 << AW;

  generate
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("ram_dp_be: RD_LAT must be 1 or 2");
    end
    if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw_mode
      $error("ram_dp_be: RDW_MODE must be 0 or 1");
    end
  endgenerate

  logic [W-1:0] mem [DEPTH];

  // Per-port views so both ports share one description below.
  logic [1:0]    acc;
  logic [1:0]    wr;
  logic [AW-1:0] addr [2];
  logic [MW-1:0] we   [2];
  logic [W-1:0]  din  [2];
  logic [W-1:0]  rd   [2];

  // Reset low blocks every access, including the write in that same cycle.
  assign acc[0]  = resetn & p0.en;
  assign acc[1]  = resetn & p1.en;
  assign addr[0] = p0.addr;
  assign addr[1] = p1.addr;
  assign we[0]   = p0.we;
  assign we[1]   = p1.we;
  assign din[0]  = p0.d;
  assign din[1]  = p1.d;
  assign wr[0]   = acc[0] & (|p0.we);
  assign wr[1]   = acc[1] & (|p1.we);

  function automatic logic [W-1:0] merge_lanes(input logic [W-1:0] old_w,
                                               input logic [W-1:0] new_w,
                                               input logic [MW-1:0] lane_we);
    logic [W-1:0] res;
    res = old_w;
    for (int i = 0; i < MW; i++) begin
      if (lane_we[i]) res[i*DW +: DW] = new_w[i*DW +: DW];
    end
    return res;
  endfunction

  // A port never sees the other port's same-cycle write; write-first only
  // overlays the port's own written lanes on the pre-write word.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = mem[addr[p]];
      if (RDW_MODE == 1) rd[p] = merge_lanes(mem[addr[p]], din[p], we[p]);
    end
  end

  // Port1 lanes are written first so port0 takes any lane both ports enable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MW; i++) begin
      if (acc[1] && we[1][i]) mem[addr[1]][i*DW +: DW] <= din[1][i*DW +: DW];
      if (acc[0] && we[0][i]) mem[addr[0]][i*DW +: DW] <= din[0][i*DW +: DW];
    end
  end

  logic [W-1:0] s1_q [2];
  logic [1:0]   s1_v;
  logic [W-1:0] q_o  [2];
  logic [1:0]   v_o;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_v <= '0;
      for (int p = 0; p < 2; p++) s1_q[p] <= '0;
    end else begin
      s1_v <= acc;
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) s1_q[p] <= rd[p];
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [W-1:0] s2_q [2];
      logic [1:0]   s2_v;
      // Second stage takes data only for a valid first-stage beat so q holds otherwise.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          s2_v <= '0;
          for (int p = 0; p < 2; p++) s2_q[p] <= '0;
        end else begin
          s2_v <= s1_v;
          for (int p = 0; p < 2; p++) begin
            if (s1_v[p]) s2_q[p] <= s1_q[p];
          end
        end
      end
      assign q_o[0] = s2_q[0];
      assign q_o[1] = s2_q[1];
      assign v_o    = s2_v;
    end else begin : g_lat1
      assign q_o[0] = s1_q[0];
      assign q_o[1] = s1_q[1];
      assign v_o    = s1_v;
    end
  endgenerate

  assign p0.q      = q_o[0];
  assign p1.q      = q_o[1];
  assign p0.rvalid = v_o[0];
  assign p1.rvalid = v_o[1];

  logic coll_now;
  assign coll_now = acc[0] & acc[1] & (addr[0] == addr[1]) & (wr[0] | wr[1]);

  always_ff @(posedge clk) begin
    if (!resetn) coll <= 1'b0;
    else         coll <= coll_now;
  end

`ifdef RAM_COLL_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn)                             coll_cnt <= '0;
    else if (coll && coll_cnt != 16'hFFFF)   coll_cnt <= coll_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: DUT A (RD_LAT=1, read-first) and DUT B (RD_LAT=2, write-first)
// share one stimulus stream; optional RAM_COLL_STATS_EN exercises the collision counter.
module tb_ram_dp_be;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en0 = 1'b0, en1 = 1'b0;
  logic [3:0]  addr0 = '0, addr1 = '0;
  logic [3:0]  we0 = '0, we1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic        coll_a, coll_b;
`ifdef RAM_COLL_STATS_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  ram_dp_be_if #(.AW(4), .MW(4), .DW(8)) a0_if ();
  ram_dp_be_if #(.AW(4), .MW(4), .DW(8)) a1_if ();
  ram_dp_be_if #(.AW(4), .MW(4), .DW(8)) b0_if ();
  ram_dp_be_if #(.AW(4), .MW(4), .DW(8)) b1_if ();

  assign a0_if.en = en0;   assign a0_if.addr = addr0; assign a0_if.we = we0; assign a0_if.d = d0;
  assign a1_if.en = en1;   assign a1_if.addr = addr1; assign a1_if.we = we1; assign a1_if.d = d1;
  assign b0_if.en = en0;   assign b0_if.addr = addr0; assign b0_if.we = we0; assign b0_if.d = d0;
  assign b1_if.en = en1;   assign b1_if.addr = addr1; assign b1_if.we = we1; assign b1_if.d = d1;

  ram_dp_be #(.AW(4), .MW(4), .DW(8), .RD_LAT(1), .RDW_MODE(0)) dut_a (
    .clk(clk), .resetn(rst_n), .p0(a0_if), .p1(a1_if), .coll(coll_a)
`ifdef RAM_COLL_STATS_EN
    , .coll_cnt(cnt_a)
`endif
  );

  ram_dp_be #(.AW(4), .MW(4), .DW(8), .RD_LAT(2), .RDW_MODE(1)) dut_b (
    .clk(clk), .resetn(rst_n), .p0(b0_if), .p1(b1_if), .coll(coll_b)
`ifdef RAM_COLL_STATS_EN
    , .coll_cnt(cnt_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] ref_mem [16];
  int          lat_of  [2] = '{1, 2};
  int          mode_of [2] = '{0, 1};
  logic [31:0] exp_q0 [$];
  logic        pend_v [2][2];
  logic [31:0] pend_d [2][2];
  logic [31:0] hold   [2][2];
  logic        exp_v  [2][2];
  logic        exp_coll = 1'b0;
  logic [15:0] exp_cnt = '0;

  typedef struct {
    logic        e0; logic [3:0] a0; logic [3:0] w0; logic [31:0] dd0;
    logic        e1; logic [3:0] a1; logic [3:0] w1; logic [31:0] dd1;
    logic [31:0] q0; logic       rv0; logic       cl;
  } vec_t;
  vec_t vec [12];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] lane_we);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (lane_we[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic e_0, input logic [3:0] a_0, input logic [3:0] w_0,
                       input logic [31:0] v_0, input logic e_1, input logic [3:0] a_1,
                       input logic [3:0] w_1, input logic [31:0] v_1);
    en0 = e_0; addr0 = a_0; we0 = w_0; d0 = v_0;
    en1 = e_1; addr1 = a_1; we1 = w_1; d1 = v_1;
  endtask

  // Advance one clock, updating the model from the current inputs, then compare.
  task automatic step(input bit do_chk);
    logic        e [2];
    logic [3:0]  a [2];
    logic [3:0]  w [2];
    logic [31:0] v [2];
    logic [31:0] rdv [2][2];
    logic        coll_next;
    e[0] = en0; a[0] = addr0; w[0] = we0; v[0] = d0;
    e[1] = en1; a[1] = addr1; w[1] = we1; v[1] = d1;
    for (int dt = 0; dt < 2; dt++)
      for (int p = 0; p < 2; p++)
        rdv[dt][p] = (mode_of[dt] == 1) ? merge(ref_mem[a[p]], v[p], w[p]) : ref_mem[a[p]];
    coll_next = rst_n && e[0] && e[1] && (a[0] == a[1]) && (w[0] != 0 || w[1] != 0);
    if (rst_n) begin
      if (e[1]) ref_mem[a[1]] = merge(ref_mem[a[1]], v[1], w[1]);
      if (e[0]) ref_mem[a[0]] = merge(ref_mem[a[0]], v[0], w[0]);
    end
    if (!rst_n) exp_cnt = '0;
    else if (exp_coll && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    exp_coll = coll_next;
    for (int dt = 0; dt < 2; dt++)
      for (int p = 0; p < 2; p++) begin
        if (!rst_n) begin
          hold[dt][p] = '0; pend_v[dt][p] = 1'b0; exp_v[dt][p] = 1'b0;
        end else if (lat_of[dt] == 1) begin
          exp_v[dt][p] = e[p];
          if (e[p]) hold[dt][p] = rdv[dt][p];
        end else begin
          exp_v[dt][p] = pend_v[dt][p];
          if (pend_v[dt][p]) hold[dt][p] = pend_d[dt][p];
          pend_v[dt][p] = e[p];
          pend_d[dt][p] = rdv[dt][p];
        end
      end
    @(posedge clk);
    #1;
    if (do_chk) begin
      check("a_q0", a0_if.q, hold[0][0]);   check("a_rv0", {31'b0, a0_if.rvalid}, {31'b0, exp_v[0][0]});
      check("a_q1", a1_if.q, hold[0][1]);   check("a_rv1", {31'b0, a1_if.rvalid}, {31'b0, exp_v[0][1]});
      check("b_q0", b0_if.q, hold[1][0]);   check("b_rv0", {31'b0, b0_if.rvalid}, {31'b0, exp_v[1][0]});
      check("b_q1", b1_if.q, hold[1][1]);   check("b_rv1", {31'b0, b1_if.rvalid}, {31'b0, exp_v[1][1]});
      check("a_coll", {31'b0, coll_a}, {31'b0, exp_coll});
      check("b_coll", {31'b0, coll_b}, {31'b0, exp_coll});
`ifdef RAM_COLL_STATS_EN
      check("a_cnt", {16'b0, cnt_a}, {16'b0, exp_cnt});
      check("b_cnt", {16'b0, cnt_b}, {16'b0, exp_cnt});
`endif
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    for (int dt = 0; dt < 2; dt++)
      for (int p = 0; p < 2; p++) begin
        pend_v[dt][p] = 1'b0; pend_d[dt][p] = '0; hold[dt][p] = '0; exp_v[dt][p] = 1'b0;
      end

    // Directed vectors, expected values are for DUT A (RD_LAT=1, read-first).
    vec[0]  = '{1'b1, 4'd3, 4'hF, 32'hA1B2C3D4, 1'b0, 4'd0, 4'h0, 32'h0,        32'h00000000, 1'b1, 1'b0};
    vec[1]  = '{1'b1, 4'd3, 4'h0, 32'h0,        1'b0, 4'd0, 4'h0, 32'h0,        32'hA1B2C3D4, 1'b1, 1'b0};
    vec[2]  = '{1'b1, 4'd5, 4'hF, 32'h11223344, 1'b0, 4'd0, 4'h0, 32'h0,        32'h00000000, 1'b1, 1'b0};
    vec[3]  = '{1'b1, 4'd5, 4'h5, 32'hAABBCCDD, 1'b0, 4'd0, 4'h0, 32'h0,        32'h11223344, 1'b1, 1'b0};
    vec[4]  = '{1'b1, 4'd5, 4'h0, 32'h0,        1'b0, 4'd0, 4'h0, 32'h0,        32'h11BB33DD, 1'b1, 1'b0};
    vec[5]  = '{1'b1, 4'd7, 4'hF, 32'hFFFFFFFF, 1'b0, 4'd0, 4'h0, 32'h0,        32'h00000000, 1'b1, 1'b0};
    vec[6]  = '{1'b1, 4'd7, 4'h0, 32'h0,        1'b0, 4'd0, 4'h0, 32'h0,        32'hFFFFFFFF, 1'b1, 1'b0};
    vec[7]  = '{1'b1, 4'd9, 4'h3, 32'h11111111, 1'b1, 4'd9, 4'h6, 32'h22222222, 32'h00000000, 1'b1, 1'b1};
    vec[8]  = '{1'b1, 4'd9, 4'h0, 32'h0,        1'b1, 4'd9, 4'h0, 32'h0,        32'h00221111, 1'b1, 1'b0};
    vec[9]  = '{1'b0, 4'd9, 4'h0, 32'h0,        1'b0, 4'd0, 4'h0, 32'h0,        32'h00221111, 1'b0, 1'b0};
    vec[10] = '{1'b0, 4'd3, 4'hF, 32'hDEADBEEF, 1'b0, 4'd0, 4'h0, 32'h0,        32'h00221111, 1'b0, 1'b0};
    vec[11] = '{1'b1, 4'd3, 4'h0, 32'h0,        1'b0, 4'd0, 4'h0, 32'h0,        32'hA1B2C3D4, 1'b1, 1'b0};

    // Reset state
    rst_n = 1'b0;
    step(1'b1);
    step(1'b1);
    rst_n = 1'b1;

    // Array contents are never reset, so clear them through the ports first.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'(i), 4'hF, 32'h0, 1'b1, 4'(i + 8), 4'hF, 32'h0);
      step(1'b0);
    end
    drive(1'b1, 4'd0, 4'h0, 32'h0, 1'b1, 4'd0, 4'h0, 32'h0);
    step(1'b0);
    drive(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 4'h0, 32'h0);
    step(1'b0);
    step(1'b1);

    for (int k = 0; k < 12; k++) begin
      drive(vec[k].e0, vec[k].a0, vec[k].w0, vec[k].dd0, vec[k].e1, vec[k].a1, vec[k].w1, vec[k].dd1);
      step(1'b1);
      check($sformatf("vec%0d_q0", k), a0_if.q, vec[k].q0);
      check($sformatf("vec%0d_rv0", k), {31'b0, a0_if.rvalid}, {31'b0, vec[k].rv0});
      check($sformatf("vec%0d_coll", k), {31'b0, coll_a}, {31'b0, vec[k].cl});
    end

    // RD_LAT=2: rvalid exactly two edges after the request, for one cycle only.
    drive(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 4'h0, 32'h0);
    step(1'b1);
    drive(1'b1, 4'd3, 4'h0, 32'h0, 1'b0, 4'd0, 4'h0, 32'h0);
    step(1'b1);
    check("lat2_early_rv", {31'b0, b0_if.rvalid}, 32'd0);
    drive(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 4'h0, 32'h0);
    step(1'b1);
    check("lat2_rv", {31'b0, b0_if.rvalid}, 32'd1);
    check("lat2_q", b0_if.q, 32'hA1B2C3D4);
    step(1'b1);
    check("lat2_rv_drop", {31'b0, b0_if.rvalid}, 32'd0);

    // Write-first on DUT B, read-first on DUT A, same write.
    drive(1'b1, 4'd10, 4'hF, 32'hFFFFFFFF, 1'b0, 4'd0, 4'h0, 32'h0);
    step(1'b1);
    check("rdw_old_a", a0_if.q, 32'h00000000);
    drive(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 4'h0, 32'h0);
    step(1'b1);
    check("rdw_new_b", b0_if.q, 32'hFFFFFFFF);

    // Back-to-back reads 0..3 with reset on the second cycle.
    drive(1'b1, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 4'h0, 32'h0);
    step(1'b1);
    rst_n = 1'b0;
    drive(1'b1, 4'd1, 4'hF, 32'h5A5A5A5A, 1'b0, 4'd0, 4'h0, 32'h0);
    step(1'b1);
    check("rst_q_b", b0_if.q, 32'h0);
    check("rst_rv_b", {31'b0, b0_if.rvalid}, 32'd0);
    check("rst_q_a", a0_if.q, 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 4'd2, 4'h0, 32'h0, 1'b0, 4'd0, 4'h0, 32'h0);
    step(1'b1);
    check("rst_drop_rv_b", {31'b0, b0_if.rvalid}, 32'd0);
    check("rst_drop_q_b", b0_if.q, 32'h0);
    drive(1'b1, 4'd3, 4'h0, 32'h0, 1'b0, 4'd0, 4'h0, 32'h0);
    step(1'b1);
    check("post_rst_a", a0_if.q, 32'hA1B2C3D4);
    check("post_rst_rv_b", {31'b0, b0_if.rvalid}, 32'd1);
    drive(1'b1, 4'd1, 4'h0, 32'h0, 1'b0, 4'd0, 4'h0, 32'h0);
    step(1'b1);
    check("post_rst_b", b0_if.q, 32'hA1B2C3D4);
    check("blocked_write_a", a0_if.q, 32'h0);

    // Randomized traffic, narrow address range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, $urandom,
            1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, $urandom);
      rst_n = ($urandom_range(0, 39) != 0);
      step(1'b1);
    end
    rst_n = 1'b1;

`ifdef RAM_COLL_STATS_EN
    // Drive the counter into saturation with continuous collisions.
    drive(1'b1, 4'd6, 4'hF, 32'h12345678, 1'b1, 4'd6, 4'h1, 32'h87654321);
    for (int n = 0; n < 65540; n++) step(1'b0);
    step(1'b1);
    check("cnt_sat_a", {16'b0, cnt_a}, 32'h0000FFFF);
    step(1'b1);
    check("cnt_hold_b", {16'b0, cnt_b}, 32'h0000FFFF);
`endif

    drive(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 4'h0, 32'h0);
    step(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
